// File: rtl/instr_encoder_pkg.sv
// Shared KGP-RISC encoding definitions: mnemonics, opcodes, field positions.
// Also imported by the core's controller.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    MN_ADD, MN_SUB, MN_AND, MN_OR, MN_XOR, MN_NOT, MN_SLA, MN_SLL, MN_SRA, MN_SRL,
    MN_ADDI, MN_SUBI, MN_ANDI, MN_ORI, MN_XORI, MN_NOTI, MN_SLAI, MN_SLLI, MN_SRAI, MN_SRLI,
    MN_MOVE, MN_LD, MN_ST, MN_BR, MN_BMI, MN_BPL, MN_BZ
  } mnem_e;

  localparam logic [5:0] OP_R       = 6'b000000;
  localparam logic [5:0] OP_I_BASE  = 6'b010000;
  localparam logic [5:0] OP_MOVE    = 6'b011010;
  localparam logic [5:0] OP_LD      = 6'b100001;
  localparam logic [5:0] OP_ST      = 6'b100010;
  localparam logic [5:0] OP_BR_BASE = 6'b110000;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int IMM_W   = 16;
  localparam int OFS_W   = 26;

  typedef struct packed {
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        last;
  } sym_instr_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_WRITE, ST_DONE} enc_state_e;

  // True when v, read as signed, survives truncation to w bits.
  function automatic logic fits_signed(input logic [31:0] v, input int w);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (w - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Symbolic-instruction stream plus instruction-memory write port.
interface instr_encoder_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_imm, in_last, imem_ack,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_imm, in_last, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational mnemonic+fields -> 32-bit word, illegal, range error.
// Range checking exists only when ENC_RANGE_CHECK_EN is defined.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_err_o
);
  logic [5:0] opc;

  always_comb begin
    word_o      = '0;
    illegal_o   = 1'b0;
    range_err_o = 1'b0;
    opc         = OP_R;
    if (mnem_i <= 5'd9) begin
      word_o = {OP_R, rs_i, rt_i, 10'b0, {1'b0, mnem_i} + 6'd1};
    end else if (mnem_i <= 5'd22) begin
      if (mnem_i <= 5'd19)       opc = OP_I_BASE + {1'b0, mnem_i - 5'd10};
      else if (mnem_i == 5'd20)  opc = OP_MOVE;
      else if (mnem_i == 5'd21)  opc = OP_LD;
      else                       opc = OP_ST;
      word_o = {opc, rs_i, rt_i, imm_i[IMM_W-1:0]};
`ifdef ENC_RANGE_CHECK_EN
      range_err_o = !fits_signed(imm_i, IMM_W);
`endif
    end else if (mnem_i <= 5'd26) begin
      opc    = OP_BR_BASE + {1'b0, mnem_i - 5'd23};
      word_o = {opc, imm_i[OFS_W-1:0]};
`ifdef ENC_RANGE_CHECK_EN
      range_err_o = !fits_signed(imm_i, OFS_W);
`endif
    end else begin
      illegal_o = 1'b1;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// KGP-RISC program loader: encodes symbolic instructions, writes them to imem,
// then releases the core. ENC_RANGE_CHECK_EN enables immediate range checking.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus,
  input  logic            restart,
  output logic            cpu_run,
  output logic            err_illegal,
  output logic            err_overflow,
  output logic            err_range
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP  = '1;

  enc_state_e        state_q, state_d;
  sym_instr_t        fld_q, fld_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              err_ill_q, err_ill_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_rng_q, err_rng_d;
  enc_state_e        drop_to;

  logic [31:0] pk_word;
  logic        pk_illegal, pk_rng;

  instr_pack u_pack (
    .mnem_i      (fld_q.mnem),
    .rs_i        (fld_q.rs),
    .rt_i        (fld_q.rt),
    .imm_i       (fld_q.imm),
    .word_o      (pk_word),
    .illegal_o   (pk_illegal),
    .range_err_o (pk_rng)
  );

  always_comb begin
    state_d   = state_q;
    fld_d     = fld_q;
    word_d    = word_q;
    addr_d    = addr_q;
    full_d    = full_q;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;
    err_rng_d = err_rng_q;
    drop_to   = fld_q.last ? ST_DONE : ST_IDLE;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        fld_d   = '{mnem: bus.in_mnem, rs: bus.in_rs, rt: bus.in_rt,
                    imm: bus.in_imm, last: bus.in_last};
        state_d = ST_ENC;
      end
      ST_ENC: begin
        word_d = pk_word;
        if (pk_illegal) begin
          err_ill_d = 1'b1;
          state_d   = drop_to;
        end else if (pk_rng) begin
          err_rng_d = 1'b1;
          state_d   = drop_to;
        end else if (full_q) begin
          err_ovf_d = 1'b1;
          state_d   = drop_to;
        end else begin
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: if (bus.imem_ack) begin
        // Saturate at the top word; the full flag then blocks further writes.
        if (addr_q == TOP) full_d = 1'b1;
        else               addr_d = addr_q + 1'b1;
        state_d = drop_to;
      end
      ST_DONE: if (restart) begin
        addr_d  = BASE;
        full_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      fld_q     <= '0;
      word_q    <= '0;
      addr_q    <= BASE;
      full_q    <= 1'b0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_rng_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fld_q     <= fld_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
      err_rng_q <= err_rng_d;
    end
  end

  // Outputs decode straight from the state register so reset drops them at once.
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word_q;
  assign cpu_run        = (state_q == ST_DONE);
  assign err_illegal    = err_ill_q;
  assign err_overflow   = err_ovf_q;
`ifdef ENC_RANGE_CHECK_EN
  assign err_range      = err_rng_q;
`else
  assign err_range      = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: randomized programs, reference model,
// decoupled write monitor with randomized acknowledge latency.
module tb_instr_encoder;
  localparam int AW   = 3;
  localparam int NWRD = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  logic cpu_run, err_illegal, err_overflow, err_range;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bus),
    .restart      (restart),
    .cpu_run      (cpu_run),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow),
    .err_range    (err_range)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int ack_delay = 0;
  bit rand_ack = 1'b0;
  int last_hold = 0;

  // model state
  int m_addr = 0;
  bit m_full = 1'b0;
  bit m_ill = 1'b0, m_ovf = 1'b0, m_rng = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encoding from the ISA tables; kind 0 = ok, 1 = illegal, 2 = out of range.
  function automatic void ref_enc(input int m, input int rs, input int rt,
                                  input logic [31:0] imm,
                                  output logic [31:0] w, output int kind);
    int op;
    longint si;
    si = longint'($signed(imm));
    w = 32'h0;
    kind = 0;
    if (m < 10) begin
      w = (32'(rs) << 21) | (32'(rt) << 16) | 32'(m + 1);
    end else if (m < 23) begin
      if (m < 20)       op = 16 + (m - 10);
      else if (m == 20) op = 26;
      else if (m == 21) op = 33;
      else              op = 34;
      w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (imm & 32'h0000_FFFF);
`ifdef ENC_RANGE_CHECK_EN
      if (si < -32768 || si > 32767) kind = 2;
`endif
    end else if (m < 27) begin
      op = 48 + (m - 23);
      w = (32'(op) << 26) | (imm & 32'h03FF_FFFF);
`ifdef ENC_RANGE_CHECK_EN
      if (si < -(64'sd1 << 25) || si > (64'sd1 << 25) - 1) kind = 2;
`endif
    end else begin
      kind = 1;
    end
  endfunction

  // Write monitor: drives ack after ack_delay extra cycles, pops and compares.
  logic [AW+31:0] held;
  int hold = 0;
  always @(negedge clk) begin
    if (bus.imem_we) begin
      if (hold > 0) chk("hold_stable", 64'({bus.imem_addr, bus.imem_wdata}), 64'(held));
      held = {bus.imem_addr, bus.imem_wdata};
      hold++;
      if (hold > ack_delay) begin
        bus.imem_ack = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
          chk("wr_data", 64'(bus.imem_wdata), 64'(e.data));
        end
        last_hold = hold;
        hold = 0;
        if (rand_ack) ack_delay = $urandom_range(0, 3);
      end else begin
        bus.imem_ack = 1'b0;
      end
    end else begin
      hold = 0;
      bus.imem_ack = 1'($urandom_range(0, 1));  // must be ignored outside WRITE
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 60) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_err_illegal"},  64'(err_illegal),  64'(m_ill));
    chk({tag, "_err_overflow"}, 64'(err_overflow), 64'(m_ovf));
    chk({tag, "_err_range"},    64'(err_range),    64'(m_rng));
  endtask

  task automatic wait_run();
    int n = 0;
    while (!cpu_run && n < 60) begin @(negedge clk); n++; end
    chk("cpu_run_rise", 64'(cpu_run), 64'd1);
    chk("done_in_ready", 64'(bus.in_ready), 64'd0);
    chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
    check_flags("done");
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_run_low", 64'(cpu_run), 64'd0);
    chk("restart_ready", 64'(bus.in_ready), 64'd1);
    m_addr = 0;
    m_full = 1'b0;
  endtask

  // Issue one instruction; called at a negedge.
  task automatic send(input int m, input int rs, input int rt,
                      input logic [31:0] imm, input bit last);
    logic [31:0] w;
    int kind;
    bit wr;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_mnem  = 5'(m);
    bus.in_rs    = 5'(rs);
    bus.in_rt    = 5'(rt);
    bus.in_imm   = imm;
    bus.in_last  = last;
    restart      = 1'($urandom_range(0, 1));  // ignored outside DONE
    ref_enc(m, rs, rt, imm, w, kind);
    wr = 1'b0;
    if (kind == 1)   m_ill = 1'b1;
    else if (kind == 2) m_rng = 1'b1;
    else if (m_full) m_ovf = 1'b1;
    else begin
      exp_q.push_back('{addr: m_addr, data: w});
      wr = 1'b1;
      if (m_addr == NWRD - 1) m_full = 1'b1;
      else m_addr++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    restart = 1'b0;
    chk("enc_in_ready", 64'(bus.in_ready), 64'd0);
    chk("enc_we_low", 64'(bus.imem_we), 64'd0);
    @(negedge clk);
    chk("we_at_n2", 64'(bus.imem_we), 64'(wr));
    if (last) wait_run();
  endtask

  function automatic logic [31:0] rnd_imm();
    int sel = $urandom_range(0, 3);
    case (sel)
      0: return 32'($signed($urandom_range(0, 40)) - 20);
      1: case ($urandom_range(0, 3))
           0: return 32'sd32767;  1: return 32'sd32768;
           2: return -32'sd32768; default: return -32'sd32769;
         endcase
      2: case ($urandom_range(0, 3))
           0: return 32'sd33554431;  1: return 32'sd33554432;
           2: return -32'sd33554432; default: return -32'sd33554433;
         endcase
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_mnem = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_imm = '0; bus.in_last = 1'b0; bus.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_cpu_run", 64'(cpu_run), 64'd0);
    check_flags("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // ADD r1,r2 ; ADDI r3,r4,#-1 (last), immediate ack
    ack_delay = 0;
    send(0, 1, 2, 32'h0, 1'b0);
    send(10, 3, 4, 32'hFFFF_FFFF, 1'b1);
    do_restart();

    // BZ +5 with ack held off: imem_we stays up four cycles
    ack_delay = 3;
    send(26, 0, 0, 32'd5, 1'b1);
    chk("bz_hold_cycles", 64'(last_hold), 64'd4);
    ack_delay = 0;
    do_restart();

    // illegal mnemonic is dropped; next legal one lands at the same address
    send(29, 3, 3, 32'd7, 1'b0);
    send(1, 5, 6, 32'd0, 1'b1);
    do_restart();

    // LD r1,r2,#8 after restart goes to address 0
    send(21, 1, 2, 32'd8, 1'b1);
    do_restart();

    // fill memory, then one more overflows
    for (int i = 0; i <= NWRD; i++) send(i % 27, i, 31 - i, 32'(i), i == NWRD);
    do_restart();

    // ADDI #40000: range error with the check enabled, truncated otherwise
    send(10, 2, 3, 32'd40000, 1'b1);
    do_restart();

    // reset in the middle of a write
    ack_delay = 100;
    send(20, 7, 8, 32'h1234, 1'b0);
    @(negedge clk);
    chk("pre_reset_we", 64'(bus.imem_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we_drop", 64'(bus.imem_we), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("reset_addr", 64'(bus.imem_addr), 64'd0);
    chk("reset_cpu_run", 64'(cpu_run), 64'd0);
    exp_q.delete();
    m_addr = 0; m_full = 1'b0; m_ill = 1'b0; m_ovf = 1'b0; m_rng = 1'b0;
    check_flags("reset");
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    @(negedge clk);

    // randomized programs with random ack latency
    rand_ack = 1'b1;
    for (int p = 0; p < 20; p++) begin
      int len = $urandom_range(1, 11);
      for (int k = 0; k < len; k++)
        send($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             rnd_imm(), k == len - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("done_hold_run", 64'(cpu_run), 64'd1);
      do_restart();
    end

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
